// File: rtl/fpga_cfg_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_DONE
    } cfg_state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One serial CRC-16-CCITT step, MSB-first, no reflection.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Byte-stream handshake carrying the bitstream into the loader.
interface fpga_cfg_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/fpga_cfg_loader_crc16.sv
// Serial CRC-16-CCITT accumulator with synchronous init.
// Latency: result visible the cycle after en; no backpressure.
// init wins over en; reset and init both load CRC_INIT.
module cfg_crc16
    import fpga_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    always_ff @(posedge clk) begin
        if (reset || init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Serializes a byte-stream bitstream MSB-first onto the fabric config chain with a divided prog_clk.
// Latency: start -> busy 1 cycle; each bit 2*DIV cycles; each byte adds one FETCH cycle.
// Backpressure: s_ready only in FETCH; an absent s_valid parks the loader in FETCH with prog_clk low.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int DIV       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    fpga_cfg_loader_if.slave bs,
    output logic             prog_clk,
    output logic             ccff_head,
    input  logic             ccff_tail,
    output logic             busy,
    output logic             done,
    output logic             fabric_hold,
    output logic [15:0]      head_crc,
    output logic [15:0]      tail_crc
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int PH_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(DIV - 1);

    cfg_state_t       state, state_nxt;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       sreg;
    logic             phase_last;
    logic             crc_init, crc_en;
    logic             prog_clk_nxt, busy_nxt, done_nxt, hold_nxt;

    assign phase_last = (phase == LAST_PH);
    assign bs.s_ready = (state == ST_FETCH);
    assign ccff_head  = sreg[7];
    assign crc_init   = (state == ST_IDLE) && start;
    // Tail is sampled in the last low cycle, just before the fabric's shift edge.
    assign crc_en     = (state == ST_SHIFT_LO) && phase_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (start) state_nxt = ST_FETCH;
            ST_FETCH:    if (bs.s_valid) state_nxt = ST_SHIFT_LO;
            ST_SHIFT_LO: if (phase_last) state_nxt = ST_SHIFT_HI;
            ST_SHIFT_HI: begin
                if (phase_last) begin
                    if (bit_cnt == LAST_BIT)  state_nxt = ST_DONE;
                    else if (bit_idx == 3'd7) state_nxt = ST_FETCH;
                    else                      state_nxt = ST_SHIFT_LO;
                end
            end
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        busy_nxt     = state_nxt inside {ST_FETCH, ST_SHIFT_LO, ST_SHIFT_HI};
        prog_clk_nxt = (state_nxt == ST_SHIFT_HI);
        done_nxt     = (state_nxt == ST_DONE);
        hold_nxt     = fabric_hold;
        if (busy_nxt) begin
            hold_nxt = 1'b1;
        end else if (done_nxt) begin
            hold_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= '0;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            sreg        <= '0;
            prog_clk    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fabric_hold <= 1'b1;
        end else begin
            prog_clk    <= prog_clk_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            fabric_hold <= hold_nxt;

            if ((state == ST_SHIFT_LO || state == ST_SHIFT_HI) && !phase_last) begin
                phase <= phase + 1'b1;
            end else begin
                phase <= '0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (start) bit_cnt <= '0;
                end
                ST_FETCH: begin
                    if (bs.s_valid) begin
                        sreg    <= bs.s_data;
                        bit_idx <= '0;
                    end
                end
                ST_SHIFT_HI: begin
                    if (phase_last) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        bit_idx <= bit_idx + 1'b1;
                        // Head changes only on the falling prog_clk edge.
                        if (state_nxt == ST_SHIFT_LO) sreg <= {sreg[6:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    cfg_crc16 u_head_crc (
        .clk    (clk),
        .reset  (reset),
        .init   (crc_init),
        .en     (crc_en),
        .bit_in (ccff_head),
        .crc    (head_crc)
    );

    cfg_crc16 u_tail_crc (
        .clk    (clk),
        .reset  (reset),
        .init   (crc_init),
        .en     (crc_en),
        .bit_in (ccff_tail),
        .crc    (tail_crc)
    );

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: a 16-bit chain (dut 0) and a 12-bit partial-byte chain (dut 1), DIV=2.
module tb_fpga_cfg_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start_s[2];
    logic [7:0] sdat[2];
    logic       svld[2];
    logic       srdy[2];
    logic       pclk[2], head[2], tail[2], busy[2], done_o[2], hold[2];
    logic [15:0] hcrc[2], tcrc[2];

    // Fabric chain models, shifted on each observed prog_clk rise.
    logic [15:0] chain_a = 16'h0000;
    logic [11:0] chain_b = 12'h000;
    assign tail[0] = chain_a[15];
    assign tail[1] = chain_b[11];

    fpga_cfg_loader_if bus_a ();
    fpga_cfg_loader_if bus_b ();
    assign bus_a.s_data  = sdat[0];
    assign bus_a.s_valid = svld[0];
    assign srdy[0]       = bus_a.s_ready;
    assign bus_b.s_data  = sdat[1];
    assign bus_b.s_valid = svld[1];
    assign srdy[1]       = bus_b.s_ready;

    fpga_cfg_loader #(.CHAIN_LEN(16), .DIV(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_s[0]), .bs(bus_a),
        .prog_clk(pclk[0]), .ccff_head(head[0]), .ccff_tail(tail[0]),
        .busy(busy[0]), .done(done_o[0]), .fabric_hold(hold[0]),
        .head_crc(hcrc[0]), .tail_crc(tcrc[0])
    );

    fpga_cfg_loader #(.CHAIN_LEN(12), .DIV(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_s[1]), .bs(bus_b),
        .prog_clk(pclk[1]), .ccff_head(head[1]), .ccff_tail(tail[1]),
        .busy(busy[1]), .done(done_o[1]), .fabric_hold(hold[1]),
        .head_crc(hcrc[1]), .tail_crc(tcrc[1])
    );

    // Written by the stimulus process only.
    int          arm_seq[2] = '{0, 0};
    int          t0[2]      = '{0, 0};
    int          tdone[2]   = '{0, 0};
    int          nbits[2]   = '{0, 0};
    logic [15:0] ebits[2]   = '{16'h0, 16'h0};
    bit          rb[2]      = '{1'b0, 1'b0};
    bit          rst_chk    = 1'b0;

    // Written by the compare process only.
    int          n_pass = 0, n_total = 0;
    int          ack_seq[2]   = '{0, 0};
    bit          active[2]    = '{1'b0, 1'b0};
    int          edge_idx[2]  = '{0, 0};
    logic [15:0] mh[2]        = '{16'hFFFF, 16'hFFFF};
    logic [15:0] mt[2]        = '{16'hFFFF, 16'hFFFF};
    logic [15:0] last_mh[2]   = '{16'hFFFF, 16'hFFFF};
    logic        prev_pclk[2] = '{1'b0, 1'b0};
    logic        prev_tail[2] = '{1'b0, 1'b0};
    logic        prev_head[2] = '{1'b0, 1'b0};
    logic        head_hold[2] = '{1'b0, 1'b0};

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
    endtask

    // Compare process: every cycle, DUT outputs against the timeline and bit-level model.
    initial forever begin
        @(negedge clk);
        if (cyc == 1) begin
            logic [15:0] m;
            logic [7:0]  ch;
            m = 16'hFFFF;
            for (int i = 0; i < 9; i++) begin
                ch = 8'(8'h31 + i);
                for (int b = 7; b >= 0; b--) m = crc_bit(m, ch[b]);
            end
            chk("model_crc_123456789", 0, 32'(m), 32'h29B1);
        end
        for (int k = 0; k < 2; k++) begin
            if (rst_chk) begin
                chk("rst_prog_clk", k, 32'(pclk[k]), 32'd0);
                chk("rst_ccff_head", k, 32'(head[k]), 32'd0);
                chk("rst_s_ready", k, 32'(srdy[k]), 32'd0);
                chk("rst_busy", k, 32'(busy[k]), 32'd0);
                chk("rst_done", k, 32'(done_o[k]), 32'd0);
                chk("rst_fabric_hold", k, 32'(hold[k]), 32'd1);
                chk("rst_head_crc", k, 32'(hcrc[k]), 32'hFFFF);
                chk("rst_tail_crc", k, 32'(tcrc[k]), 32'hFFFF);
            end
            if (reset) begin
                active[k] = 1'b0;
            end else begin
                if (ack_seq[k] != arm_seq[k]) begin
                    ack_seq[k]  = arm_seq[k];
                    active[k]   = 1'b1;
                    edge_idx[k] = 0;
                    mh[k]       = 16'hFFFF;
                    mt[k]       = 16'hFFFF;
                end
                if (active[k]) begin
                    if (cyc > t0[k]) begin
                        chk("busy", k, 32'(busy[k]), 32'(cyc < tdone[k]));
                        chk("fabric_hold", k, 32'(hold[k]), 32'(cyc < tdone[k]));
                    end
                    chk("done", k, 32'(done_o[k]), 32'(cyc == tdone[k]));
                    if (pclk[k] && !prev_pclk[k]) begin
                        if (edge_idx[k] < nbits[k]) begin
                            logic eb;
                            eb = ebits[k][nbits[k] - 1 - edge_idx[k]];
                            chk("head_bit", k, 32'(head[k]), 32'(eb));
                            chk("head_setup", k, 32'(head[k]), 32'(prev_head[k]));
                            mh[k] = crc_bit(mh[k], eb);
                            mt[k] = crc_bit(mt[k], prev_tail[k]);
                        end
                        if (k == 0) chain_a = {chain_a[14:0], head[0]};
                        else        chain_b = {chain_b[10:0], head[1]};
                        head_hold[k] = head[k];
                        edge_idx[k]++;
                    end else if (pclk[k] && prev_pclk[k]) begin
                        chk("head_hold", k, 32'(head[k]), 32'(head_hold[k]));
                    end
                    if (cyc == tdone[k]) begin
                        chk("edge_count", k, 32'(edge_idx[k]), 32'(nbits[k]));
                        chk("head_crc", k, 32'(hcrc[k]), 32'(mh[k]));
                        chk("tail_crc", k, 32'(tcrc[k]), 32'(mt[k]));
                        if (rb[k]) chk("readback_crc", k, 32'(tcrc[k]), 32'(last_mh[k]));
                        last_mh[k] = mh[k];
                        active[k]  = 1'b0;
                    end
                end
            end
            prev_pclk[k] = pclk[k];
            prev_tail[k] = tail[k];
            prev_head[k] = head[k];
        end
    end

    // Drives one load as a byte source; start is asserted in the current cycle N.
    task automatic run_load(input int k, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [15:0] bits, input int nb, input int done_off,
                            input int stall_len, input bit readback, input int abort_at);
        int n0, bi, stall_cnt;
        bit pend;
        n0 = cyc; bi = 0; stall_cnt = 0; pend = 1'b0;
        ebits[k] = bits; nbits[k] = nb; t0[k] = n0; tdone[k] = n0 + done_off; rb[k] = readback;
        arm_seq[k]++;
        start_s[k] = 1'b1; svld[k] = 1'b1; sdat[k] = b0;
        do begin
            @(posedge clk); #2;
            start_s[k] = 1'b0;
            if (pend) bi++;
            if (abort_at > 0 && cyc == n0 + abort_at) begin
                svld[k] = 1'b0; reset = 1'b1;
                @(posedge clk); #2; reset = 1'b0; rst_chk = 1'b1;
                @(posedge clk); #2; rst_chk = 1'b0;
                return;
            end
            if (bi >= 2) begin
                svld[k] = 1'b0;
            end else if (bi == 1 && srdy[k] && stall_cnt < stall_len) begin
                svld[k] = 1'b0;
                stall_cnt++;
            end else begin
                svld[k] = 1'b1;
                sdat[k] = (bi == 0) ? b0 : b1;
            end
            pend = svld[k] && srdy[k];
            if (cyc > n0 + done_off + 20) begin
                $display("FAIL load_timeout dut%0d: no completion by cycle %0d", k, cyc);
                $fatal(1, "load did not complete");
            end
        end while (active[k] || ack_seq[k] != arm_seq[k]);
        svld[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    initial begin
        start_s = '{1'b0, 1'b0};
        svld    = '{1'b0, 1'b0};
        sdat    = '{8'h00, 8'h00};
        @(posedge clk); #2; rst_chk = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2; reset = 1'b0;
        idle(2);
        rst_chk = 1'b0;

        // Basic load: 0xA5,0x3C, done at N+67.
        run_load(0, 8'hA5, 8'h3C, 16'b1010010100111100, 16, 67, 0, 1'b0, 0);
        idle(2);
        // Same stream, 10 stalled FETCH cycles before byte 2; tail reads back the first load.
        run_load(0, 8'hA5, 8'h3C, 16'b1010010100111100, 16, 77, 10, 1'b1, 0);
        idle(2);
        // Partial final byte: 12-bit chain, 0xF0,0xAF -> 111100001010, done at N+51.
        run_load(1, 8'hF0, 8'hAF, 16'h0F0A, 12, 51, 0, 1'b0, 0);
        idle(2);
        // Abort during the high phase of bit 5 (cycles N+24..N+25).
        run_load(0, 8'hA5, 8'h3C, 16'b1010010100111100, 16, 67, 0, 1'b0, 24);
        idle(2);
        run_load(0, 8'hA5, 8'h3C, 16'b1010010100111100, 16, 67, 0, 1'b0, 0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fpga_cfg_loader.md
# fpga_cfg_loader

Configuration-chain loader for the embedded FPGA fabric. It takes a bitstream as a byte stream over a valid/ready handshake and serializes it MSB-first onto `ccff_head`, while generating `prog_clk` from the system clock. It holds the fabric in reset while loading, and computes serial CRCs of the bits shifted in and the bits observed on `ccff_tail`, so firmware can check the chain contents. It sits between the host-side byte source and `fpga_top`'s `prog_clk` / `ccff_head` / `ccff_tail` pins.

## Interface
Parameters:
- `CHAIN_LEN`, 1024: configuration chain length in bits; must be ≥ 1.
- `DIV`, 4: `prog_clk` half-period in `clk` cycles; must be ≥ 1.
- `NBYTES`, localparam = ceil(`CHAIN_LEN`/8): bytes consumed per load.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level or pulse; sampled only in IDLE.
- `s_data`  in  8  bitstream byte.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `prog_clk`  out  1  configuration shift clock to the fabric.
- `ccff_head`  out  1  serial configuration data to the fabric.
- `ccff_tail`  in  1  chain output from the fabric.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse when a load completes.
- `fabric_hold`  out  1  active-high hold-in-reset for fabric user logic.
- `head_crc`  out  16  CRC of the bits shifted in during the current or last load.
- `tail_crc`  out  16  CRC of the `ccff_tail` samples during the current or last load.

## Operation
- FSM states: IDLE, FETCH, SHIFT_LO, SHIFT_HI, DONE.
- **IDLE**
  - `start`=1 moves to FETCH.
  - On that transition: clear the bit counter, load both CRCs with 16'hFFFF, set `busy` and `fabric_hold`.
- **FETCH**
  - `s_ready`=1.
  - On `s_valid`&&`s_ready`, latch `s_data` into the shift register and go to SHIFT_LO.
  - If `s_valid` stays 0, remain in FETCH indefinitely, with `prog_clk` held 0 and no error.
- **SHIFT_LO**
  - `prog_clk`=0 and `ccff_head`=current bit, for `DIV` cycles.
  - In the last cycle, sample `ccff_tail` into the `tail_crc` update, update `head_crc` with `ccff_head`, then go to SHIFT_HI.
- **SHIFT_HI**
  - `prog_clk`=1 for `DIV` cycles; `ccff_head` stays stable.
  - On exit, increment the bit count.
  - If the count equals `CHAIN_LEN`, go to DONE.
  - Otherwise, if 8 bits of this byte have been shifted, go to FETCH; else shift the register left and go to SHIFT_LO.
- **Final partial byte:** when `CHAIN_LEN`%8≠0, only the top `CHAIN_LEN`%8 bits are shifted and the low bits are discarded.
- **DONE** (one cycle): `done`=1, `busy`=0, `fabric_hold`=0, then IDLE.
- **CRC:** CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, serial MSB-first, no reflection, no final XOR.
  - CRC values hold after DONE until the next start.
- **Start handling:** `start` outside IDLE is ignored. `start` held high in IDLE after DONE begins a new load on the following cycle.
- **Reset:** reset mid-load aborts immediately. All outputs take their reset values on the next edge; chain contents are undefined.

## Timing
- **Reset values:** `prog_clk`=0, `ccff_head`=0, `s_ready`=0, `busy`=0, `done`=0, `fabric_hold`=1, `head_crc`=`tail_crc`=16'hFFFF, state IDLE.
- **Start:** `start` at cycle N makes FETCH and `busy` visible at N+1.
- **Per bit:** 2·`DIV` cycles. Per byte: 1 FETCH cycle (with `s_valid` already high) + 8·2·`DIV` cycles.
- **Zero-stall total:** with `CHAIN_LEN`=8·`NBYTES`, `done` asserts at N+1+`NBYTES`·(1+16·`DIV`).
- **Fabric shift edge:** the fabric shifts on `prog_clk` rising edges.
  - `ccff_head` is stable ≥ `DIV` cycles before and `DIV` cycles after each rising edge.
  - `ccff_tail` is sampled at most 1 cycle before each rising edge.
- **Outputs:** all registered; no combinational input-to-output path except `s_ready` (a decode of registered state).

## Structure
- Package `fpga_cfg_pkg`:
  - state enum;
  - `CRC_POLY`=16'h1021;
  - `CRC_INIT`=16'hFFFF.
- Sub-module `cfg_crc16`: a one-bit serial CRC update with enable and synchronous init, instantiated twice (head and tail).
- Top level holds the FSM, the `DIV` phase counter, the bit counter (width $clog2(`CHAIN_LEN`+1)) and the 8-bit shift register.

## Test plan
- **Reset values:** reset asserted for 3 cycles → all outputs at reset values, `fabric_hold`=1, `prog_clk` never toggles.
- **Basic load:** `CHAIN_LEN`=16, `DIV`=2, bytes 0xA5, 0x3C with `s_valid` always high, `start` at cycle N.
  - 16 `prog_clk` rising edges.
  - `ccff_head` at successive edges = 1010010100111100.
  - `done` pulses at N+67; `fabric_hold` falls at N+67.
- **Backpressure:** same load, `s_valid` low for 10 cycles before the second byte → FETCH holds, `prog_clk` stays 0, `done` at N+77, head sequence unchanged.
- **Readback CRC:** bench models the chain as a 16-bit shift register and the same bitstream is loaded twice → second-load `tail_crc` equals first-load `head_crc`.
- **Partial byte:** `CHAIN_LEN`=12, bytes 0xF0, 0xAF → 12 edges, head sequence 111100001010, `done` after the 12th HI phase.
- **Abort:** reset asserted mid-SHIFT_HI of bit 5 → next cycle `prog_clk`=0, `busy`=0, `fabric_hold`=1. A subsequent `start` performs a full clean load.
